// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: FSM encodings, handshake levels, bus widths.
// Imported by the divider and its interface.
package div_seq_pkg;

  localparam int DivDw = 32;

  localparam logic       RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef logic [2*DivDw-1:0] double_reg_bus_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between EX and the divider; master = EX side, slave = divider.
interface div_seq_if #(parameter int DW = 32);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU: 34 cycles to ready (2 for divide-by-zero).
// Holds {remainder, quotient} with ready high for as long as EX keeps start asserted.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW = DivDw
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam logic [5:0] CntLast = 6'd32;

  logic [1:0]      r_state;
  logic [5:0]      r_cnt;
  logic [2*DW-1:0] r_part;
  logic [DW-1:0]   r_divisor;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [2*DW-1:0] r_result;
  logic            r_ready;

  logic [DW-1:0]   w_abs1;
  logic [DW-1:0]   w_abs2;
  logic [2*DW:0]   w_shift;
  logic [DW:0]     w_trial;
  logic [2*DW-1:0] w_step;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;

  assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Partial is {rem, dividend/quotient}; quotient bits shift in from the right.
  assign w_shift = {r_part, 1'b0};
  assign w_trial = w_shift[2*DW:DW] - {1'b0, r_divisor};
  assign w_step  = w_trial[DW] ? w_shift[2*DW-1:0]
                               : {w_trial[DW-1:0], w_shift[DW-1:1], 1'b1};

  assign w_quo = r_neg_q ? -r_part[DW-1:0]    : r_part[DW-1:0];
  assign w_rem = r_neg_r ? -r_part[2*DW-1:DW] : r_part[2*DW-1:DW];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_part    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            r_divisor <= w_abs2;
            r_part    <= {{DW{1'b0}}, w_abs1};
            r_neg_q   <= bus.signed_div_i && (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
            r_neg_r   <= bus.signed_div_i && bus.opdata1_i[DW-1];
            r_cnt     <= '0;
            r_state   <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          r_part  <= '0;
          r_state <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            r_state <= DivFree;
          end else if (r_cnt != CntLast) begin
            r_part <= w_step;
            r_cnt  <= r_cnt + 6'd1;
          end else begin
            // Remainder follows the dividend's sign; quotient negates on sign mismatch.
            r_part  <= {w_rem, w_quo};
            r_cnt   <= '0;
            r_state <= DivEnd;
          end
        end
        default: begin
          if (bus.start_i == DivStop || bus.annul_i) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end else begin
            r_ready  <= DivResultReady;
            r_result <= r_part;
          end
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against a plain-arithmetic reference model.
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  div_seq_if #(.DW(32)) bus ();

  div_seq #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one operation, scrambles inputs while busy, checks latency, result, hold and release.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int lat;
    logic [63:0] got;
    lat = -1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      #1;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    got = bus.result_o;
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h, expected %h", name, got, exp);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
      n_err++;
      $display("FAIL %s hold: got ready=%b result=%h, expected ready=1 result=%h",
               name, bus.ready_o, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL %s release: got ready=%b result=%h, expected ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset ready: got %b, expected 0", bus.ready_o);
    end
    n_vec++;
    if (bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset result: got %h, expected 0", bus.result_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    run_op(1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, "u_100_7");
    run_op(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34, "s_m7_2");
    run_op(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34, "s_7_m2");
    run_op(1'b0, 32'd1234,       32'd0,          64'd0,                  2, "u_div0");
    run_op(1'b1, 32'd1234,       32'd0,          64'd0,                  2, "s_div0");
    run_op(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34, "s_min_m1");
    run_op(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34, "u_max_1");
    run_op(1'b1, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34, "s_m1_1");
  endtask

  task automatic test_random;
    logic        s;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(s, a, b, ref_div(s, a, b), (b == 32'd0) ? 2 : 34, "random");
    end
  endtask

  task automatic test_annul;
    int seen;
    seen = 0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd7;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    if (bus.ready_o === 1'b1) seen++;
    run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "after_annul");
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL annul ready: got ready high %0d times, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i = 32'hDEADBEEF;
    bus.opdata2_i = 32'd13;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    n_vec++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got ready=%b result=%h, expected ready=0 result=0",
               bus.ready_o, bus.result_o);
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_mid stray ready: got %0d cycles high, expected 0", seen);
    end
    run_op(1'b0, 32'd50, 32'd6, 64'h00000002_00000008, 34, "after_reset");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_annul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
